// File: rtl/hilo_pkg.sv
// hilo_pkg: op and state encodings shared by the HI/LO sequencer and its counter.
package hilo_pkg;
  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_MULT   = 3'd1,
    OP_MULTU  = 3'd2,
    OP_MADD   = 3'd3,
    OP_MSUB   = 3'd4,
    OP_DIV    = 3'd5,
    OP_DIVU   = 3'd6,
    OP_MTHILO = 3'd7
  } hilo_op_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, WB} hilo_state_t;
  localparam int CNT_W = 6;
  function automatic logic is_mul(hilo_op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
  endfunction
  function automatic logic is_div(hilo_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/hilo_lat_counter.sv
// hilo_lat_counter: loadable down-counter with a zero flag for MUL/DIV latency.
module hilo_lat_counter import hilo_pkg::*; (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) count <= '0;
    else if (load) count <= value;
    else if (dec) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/hilo_sequencer.sv
// hilo_sequencer: sequences MUL/DIV/MT ops onto the shared HI/LO registers and stalls on hazards.
module hilo_sequencer import hilo_pkg::*; #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       Start,
  input  logic [2:0] Op,
  input  logic       ReadHiLo,
  input  logic       Flush,
  input  logic       DivZero,
  output logic       Stall,
  output logic       Busy,
  output logic       MulEn,
  output logic       DivInit,
  output logic       DivStep,
  output logic       HiLoWrite,
  output logic       HiLoSel,
  output logic [2:0] CurOp
);
  hilo_state_t state, state_d;
  hilo_op_t op, cur_op, cur_op_d;
  logic accept, load, zero;
  logic [CNT_W-1:0] load_val;
  assign op = hilo_op_t'(Op);
  assign accept = state == IDLE && Start && !Flush && op != OP_NONE;
  always_comb begin
    state_d = state;
    cur_op_d = cur_op;
    load = 1'b0;
    load_val = '0;
    case (state)
      IDLE: if (accept) begin
        cur_op_d = op;
        if (is_mul(op)) begin
          state_d = MUL;
          load = 1'b1;
          load_val = CNT_W'(MUL_LAT - 1);
        end else if (is_div(op)) begin
          if (DivZero) cur_op_d = OP_NONE;
          else begin
            state_d = DIV;
            load = 1'b1;
            load_val = CNT_W'(DIV_LAT - 1);
          end
        end else state_d = WB;
      end
      MUL, DIV: state_d = zero ? WB : state;
      default: begin
        state_d = IDLE;
        cur_op_d = OP_NONE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      cur_op <= OP_NONE;
    end else begin
      state <= state_d;
      cur_op <= cur_op_d;
    end
  hilo_lat_counter u_cnt (
    .clk(clk), .nrst(nrst), .load(load),
    .dec((state == MUL || state == DIV) && !zero),
    .value(load_val), .zero(zero)
  );
  assign Busy = state != IDLE;
  assign MulEn = state == MUL;
  assign DivStep = state == DIV;
  assign HiLoWrite = state == WB;
  assign HiLoSel = HiLoWrite && is_div(cur_op);
  // Gated by nrst so every output is quiet while reset is held.
  assign DivInit = nrst && accept && is_div(op) && !DivZero;
  assign Stall = Busy && (Start || ReadHiLo) && !Flush;
  assign CurOp = cur_op;
endmodule

// File: tb/tb_hilo_sequencer.sv
// tb_hilo_sequencer: directed + random stimulus against a cycles-since-issue reference model.
module tb_hilo_sequencer;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;
  logic clk = 1'b0, nrst = 1'b0;
  logic Start = 1'b0, ReadHiLo = 1'b0, Flush = 1'b0, DivZero = 1'b0;
  logic [2:0] Op = 3'd0;
  logic Stall, Busy, MulEn, DivInit, DivStep, HiLoWrite, HiLoSel;
  logic [2:0] CurOp;
  int n_checks = 0, n_fail = 0;
  int age = 0, m_op = 0;

  always #5 clk = ~clk;

  hilo_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .nrst(nrst), .Start(Start), .Op(Op), .ReadHiLo(ReadHiLo),
    .Flush(Flush), .DivZero(DivZero), .Stall(Stall), .Busy(Busy), .MulEn(MulEn),
    .DivInit(DivInit), .DivStep(DivStep), .HiLoWrite(HiLoWrite), .HiLoSel(HiLoSel),
    .CurOp(CurOp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_mul_op(int o); return o >= 1 && o <= 4; endfunction
  function automatic bit is_div_op(int o); return o == 5 || o == 6; endfunction
  // Commit happens lat+1 cycles after issue; the op is busy for exactly that long.
  function automatic int lat(int o);
    return is_mul_op(o) ? MUL_LAT : is_div_op(o) ? DIV_LAT : 0;
  endfunction

  task automatic model_update();
    if (!nrst) age = 0;
    else if (age == 0) begin
      if (Start && !Flush && Op != 0 && !(is_div_op(int'(Op)) && DivZero)) begin
        age = 1;
        m_op = int'(Op);
      end
    end else if (age == lat(m_op) + 1) age = 0;
    else age++;
  endtask

  task automatic check_outputs();
    bit idle, acc, wr;
    idle = age == 0;
    acc = idle && Start && !Flush && Op != 0;
    wr = !idle && age == lat(m_op) + 1;
    check("stall", 32'(Stall), 32'(!idle && (Start || ReadHiLo) && !Flush));
    check("busy", 32'(Busy), 32'(!idle));
    check("mulen", 32'(MulEn), 32'(!idle && is_mul_op(m_op) && age <= MUL_LAT));
    check("divinit", 32'(DivInit), 32'(acc && is_div_op(int'(Op)) && !DivZero));
    check("divstep", 32'(DivStep), 32'(!idle && is_div_op(m_op) && age <= DIV_LAT));
    check("hilowrite", 32'(HiLoWrite), 32'(wr));
    check("hilosel", 32'(HiLoSel), 32'(wr && is_div_op(m_op)));
    check("curop", 32'(CurOp), idle ? 32'd0 : 32'(m_op));
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({Stall, Busy, MulEn, DivInit, DivStep, HiLoWrite, HiLoSel, CurOp}), 32'd0);
  endtask

  task automatic step(input logic s, input logic [2:0] o, input logic r, input logic f, input logic z);
    @(posedge clk);
    model_update();
    #1;
    Start = s; Op = o; ReadHiLo = r; Flush = f; DivZero = z;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    Start = 1'b1; Op = 3'd5;
    repeat (2) @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk);
    #1 nrst = 1'b1; Start = 1'b0; Op = 3'd0;
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    repeat (36) step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (3000)
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    for (int i = 0; i < DIV_LAT + 4 && age != 0; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    check("idle_wait", 32'(age == 0), 32'd1);
    step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    model_update();
    #1 nrst = 1'b0; Start = 1'b1; Op = 3'd5;
    #1 check_zero("midop_reset");
    age = 0;
    @(posedge clk);
    #1 nrst = 1'b1; Start = 1'b0; Op = 3'd0;
    @(negedge clk);
    check_outputs();
    step(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_sequencer.md
Name: hilo_sequencer

Overview:
- Multi-cycle controller for the HI/LO resource shared by the MUL/ACC datapath and an iterative divider in the execute stage.
- Accepts MULT/MULTU/MADD/MSUB/DIV/DIVU/MTHI/MTLO issues from decode.
- Sequences the multiplier and divider for their fixed latencies, then commits the result to HI/LO.
- Stalls the pipeline on any HI/LO hazard (a new HI/LO op, or MFHI/MFLO, arriving while busy).

Parameters:
- MUL_LAT, 2, cycles MulEn is held for MULT/MULTU/MADD/MSUB (>=1).
- DIV_LAT, 32, DivStep cycles per DIV/DIVU (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- Start  in  1  HI/LO op present in EX this cycle.
- Op  in  3  op code (package encoding).
- ReadHiLo  in  1  MFHI/MFLO present in EX.
- Flush  in  1  EX instruction squashed this cycle.
- DivZero  in  1  divisor==0, valid with Start.
- Stall  out  1  hold PC/IF/ID/EX (combinational).
- Busy  out  1  state != IDLE.
- MulEn  out  1  multiplier advance.
- DivInit  out  1  load divider operands.
- DivStep  out  1  one divider iteration.
- HiLoWrite  out  1  commit HI/LO this cycle.
- HiLoSel  out  1  0 = MUL/ACC result, 1 = divider result.
- CurOp  out  3  registered op, drives datapath signed/accumulate/MT select.

Behaviour:
- Reset (nrst=0, asynchronous) puts the block in state IDLE with counter 0 and CurOp=OP_NONE. All outputs are 0 during reset. Reset in mid-operation abandons the op and HI/LO is not written.
- States are IDLE, MUL, DIV and WB. The counter is 6 bits.
- Accept condition: state==IDLE & Start & !Flush & Op!=OP_NONE. On acceptance, CurOp<=Op.
- IDLE transitions on accept:
  - MULT/MULTU/MADD/MSUB: go to MUL with count<=MUL_LAT-1.
  - DIV/DIVU with DivZero=0: go to DIV with count<=DIV_LAT-1, and DivInit=1 in the accept cycle (combinational).
  - DIV/DIVU with DivZero=1: go to IDLE and set CurOp<=OP_NONE. There is no HiLoWrite, so HI/LO is unchanged.
  - MTHI/MTLO: go to WB.
- MUL state: MulEn=1 every cycle. When count==0, go to WB; otherwise decrement. Exactly MUL_LAT MulEn cycles per op.
- DIV state: DivStep=1 every cycle. When count==0, go to WB; otherwise decrement. Exactly DIV_LAT DivStep cycles per op.
- WB state: HiLoWrite=1 for one cycle, HiLoSel=(CurOp is DIV/DIVU). Then go to IDLE with CurOp<=OP_NONE.
- Issue-to-commit latency: MUL ops take MUL_LAT+1 cycles, DIV ops DIV_LAT+1, MTHI/MTLO 1.
- Stall = (state!=IDLE) & (Start | ReadHiLo) & !Flush.
  - ReadHiLo during WB stalls, because the write lands at the end of WB.
  - A stalled Start is held by the pipeline and accepted in the first IDLE cycle.
  - Back-to-back ops always have one IDLE cycle between WB and the next accept.
- Flush:
  - Suppresses acceptance and stall for that cycle only.
  - Never cancels an accepted op; it has already left EX and is architecturally issued.
- Start and ReadHiLo together in IDLE: the op is accepted, no stall. The read sees the old HI/LO, which is correct program order because the read belongs to an older instruction.
- Op==OP_NONE with Start=1 is ignored and produces no state change.

Decomposition:
- Package hilo_pkg holds:
  - typedef enum logic [2:0] hilo_op_t: OP_NONE=0, OP_MULT=1, OP_MULTU=2, OP_MADD=3, OP_MSUB=4, OP_DIV=5, OP_DIVU=6, OP_MTHILO=7.
  - typedef enum logic [1:0] hilo_state_t: IDLE, MUL, DIV, WB.
- Encoding note: MTHI and MTLO share code 7, and the datapath distinguishes them via Func.
- Optional sub-module hilo_lat_counter: a loadable down-counter with a zero flag.

Test Plan:
- MULT at t0, MUL_LAT=2 -> MulEn high at t1 and t2, HiLoWrite=1 and HiLoSel=0 at t3, Busy low at t4.
- DIVU with DivZero=0, DIV_LAT=32 -> DivInit at t0, 32 DivStep cycles t1..t32, HiLoWrite=1 and HiLoSel=1 at t33.
- MFHI held from t1 during DIV -> Stall=1 from t1 through t33 (WB inclusive), 0 at t34.
- DIV with DivZero=1 -> no DivStep, no HiLoWrite, Busy stays 0.
- MULT accepted; second MULT held with Start=1 -> Stall until WB ends, second accepted in the first IDLE cycle, two HiLoWrite pulses 4 cycles apart.
- nrst low at t5 of a DIV -> all outputs 0 immediately; after release, MTHI -> HiLoWrite next cycle.
- Start with Flush=1 -> no accept, Stall=0, state stays IDLE.
